// File: rtl/matmul_stream_pkg.sv
// Shared types and default sizing for the streaming matrix-multiply block.
package matmul_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int MAX_N_DEF  = 8;
   localparam int ACC_W_DEF  = 40;
   localparam int OUT_W_DEF  = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_EMIT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/matmul_stream_if.sv
// Operand-in / result-out handshake bundle for matmul_stream.
interface matmul_stream_if
   import matmul_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OUT_W  = OUT_W_DEF
);

   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] a_data;
   logic [DATA_W-1:0] b_data;
   logic              res_valid;
   logic              res_ready;
   logic [OUT_W-1:0]  res_data;
   logic [3:0]        res_row;
   logic [3:0]        res_col;
   logic              res_last;

   modport master (
      output op_valid, a_data, b_data, res_ready,
      input  op_ready, res_valid, res_data, res_row, res_col, res_last
   );

   modport slave (
      input  op_valid, a_data, b_data, res_ready,
      output op_ready, res_valid, res_data, res_row, res_col, res_last
   );

endinterface

// File: rtl/matmul_stream_mac.sv
// Signed/unsigned multiply-accumulate step and result saturation/truncation.
module matmul_mac
   import matmul_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int OUT_W  = OUT_W_DEF
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              signed_mode,
   input  logic              sat_en,
   output logic [ACC_W-1:0]  acc_next,
   output logic [OUT_W-1:0]  res
);

   localparam int PROD_W = 2 * DATA_W;

   logic signed [PROD_W-1:0] prod_s;
   logic        [PROD_W-1:0] prod_u;
   logic        [ACC_W-1:0]  prod_ext;
   logic                     sig_fit;
   logic                     uns_fit;

   always_comb begin
      prod_s   = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
      prod_u   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      prod_ext = signed_mode ? {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s}
                             : {{(ACC_W-PROD_W){1'b0}}, prod_u};
      acc_next = acc + prod_ext;
   end

   // A signed value fits when every bit above the OUT_W sign bit matches it.
   assign sig_fit = (acc[ACC_W-1:OUT_W-1] == '0) || (acc[ACC_W-1:OUT_W-1] == '1);

   generate
      if (OUT_W < ACC_W) begin : g_uns_chk
         assign uns_fit = (acc[ACC_W-1:OUT_W] == '0);
      end else begin : g_uns_full
         assign uns_fit = 1'b1;
      end
   endgenerate

   always_comb begin
      res = acc[OUT_W-1:0];
      if (sat_en) begin
         if (signed_mode) begin
            if (!sig_fit)
               res = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
         end else if (!uns_fit) begin
            res = '1;
         end
      end
   end

endmodule

// File: rtl/matmul_stream.sv
// Streaming N x N matrix multiply: consumes A/B operand pairs, emits C elements in row-major order.
module matmul_stream
   import matmul_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int MAX_N  = MAX_N_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int OUT_W  = OUT_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] mat_n,
   input  logic       signed_mode,
   input  logic       sat_en,
   output logic       busy,
   output logic       done,
   output logic       err,
   matmul_stream_if.slave bus
);

   localparam logic [3:0] MAX_N4 = 4'(MAX_N);

   state_t            state;
   state_t            state_nx;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_next;
   logic [OUT_W-1:0]  mac_res;
   logic [3:0]        row;
   logic [3:0]        col;
   logic [3:0]        k;
   logic [3:0]        n_lat;
   logic [3:0]        n_m1;
   logic              sgn_lat;
   logic              sat_lat;
   logic              mat_ok;
   logic              accept;
   logic              handshake;
   logic              k_last;
   logic              elem_last;

   matmul_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W)
   ) u_mac (
      .acc         (acc),
      .a           (bus.a_data),
      .b           (bus.b_data),
      .signed_mode (sgn_lat),
      .sat_en      (sat_lat),
      .acc_next    (acc_next),
      .res         (mac_res)
   );

   assign n_m1      = n_lat - 4'd1;
   assign mat_ok    = (mat_n != 4'd0) && (mat_n <= MAX_N4);
   assign accept    = (state == ST_ACC) && bus.op_valid;
   assign handshake = (state == ST_EMIT) && bus.res_ready;
   assign k_last    = (k == n_m1);
   assign elem_last = (row == n_m1) && (col == n_m1);

   assign bus.op_ready  = (state == ST_ACC);
   assign bus.res_valid = (state == ST_EMIT);
   assign bus.res_data  = mac_res;
   assign bus.res_row   = row;
   assign bus.res_col   = col;
   assign bus.res_last  = (state == ST_EMIT) && elem_last;
   assign busy          = (state != ST_IDLE);
   assign done          = (state == ST_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start && mat_ok) state_nx = ST_ACC;
         ST_ACC:  if (accept && k_last) state_nx = ST_EMIT;
         ST_EMIT: if (handshake) state_nx = elem_last ? ST_DONE : ST_ACC;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         row     <= '0;
         col     <= '0;
         k       <= '0;
         n_lat   <= '0;
         sgn_lat <= 1'b0;
         sat_lat <= 1'b0;
         err     <= 1'b0;
      end else begin
         err <= (state == ST_IDLE) && start && !mat_ok;
         case (state)
            ST_IDLE: begin
               if (start && mat_ok) begin
                  acc     <= '0;
                  row     <= '0;
                  col     <= '0;
                  k       <= '0;
                  n_lat   <= mat_n;
                  sgn_lat <= signed_mode;
                  sat_lat <= sat_en;
               end
            end
            ST_ACC: begin
               if (accept) begin
                  acc <= acc_next;
                  k   <= k_last ? 4'd0 : k + 4'd1;
               end
            end
            ST_EMIT: begin
               // acc is held through the last element so res_data stays valid into DONE.
               if (handshake && !elem_last) begin
                  acc <= '0;
                  if (col == n_m1) begin
                     col <= 4'd0;
                     row <= row + 4'd1;
                  end else begin
                     col <= col + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_stream.sv
// Bench for matmul_stream: two DUTs (OUT_W 32 and 16) driven in lockstep against an arithmetic model.
module tb_matmul_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] mat_n;
   logic       signed_mode;
   logic       sat_en;
   logic       busy, done, err;
   logic       busy16, done16, err16;

   always #5 clk = ~clk;

   matmul_stream_if #(.DATA_W(16), .OUT_W(32)) bus ();
   matmul_stream_if #(.DATA_W(16), .OUT_W(16)) bus16 ();

   assign bus16.op_valid  = bus.op_valid;
   assign bus16.a_data    = bus.a_data;
   assign bus16.b_data    = bus.b_data;
   assign bus16.res_ready = bus.res_ready;

   matmul_stream #(.DATA_W(16), .MAX_N(8), .ACC_W(40), .OUT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .mat_n(mat_n), .signed_mode(signed_mode),
      .sat_en(sat_en), .busy(busy), .done(done), .err(err), .bus(bus)
   );

   matmul_stream #(.DATA_W(16), .MAX_N(8), .ACC_W(40), .OUT_W(16)) dut16 (
      .clk(clk), .rst(rst), .start(start), .mat_n(mat_n), .signed_mode(signed_mode),
      .sat_en(sat_en), .busy(busy16), .done(done16), .err(err16), .bus(bus16)
   );

   typedef struct {
      bit          sgn;
      bit          sat;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] e32;
      logic [15:0] e16;
   } vec_t;

   typedef struct {
      logic [3:0]  row;
      logic [3:0]  col;
      logic [31:0] d32;
      logic [15:0] d16;
      logic        last;
   } res_t;

   int          vecs = 0;
   int          miss = 0;
   int          err_seen = 0;
   logic [15:0] ma [0:14][0:14];
   logic [15:0] mb [0:14][0:14];
   res_t        got[$];
   vec_t        tbl[9];

   always @(negedge clk) if (err) err_seen++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bail(input string name);
      vecs++;
      miss++;
      $display("FAIL %s: timed out waiting for DUT", name);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   endtask

   function automatic longint elem(input int n, input int r, input int c, input bit sgn);
      longint s, a, b;
      s = 0;
      for (int kk = 0; kk < n; kk++) begin
         a = sgn ? longint'($signed(ma[r][kk])) : longint'(ma[r][kk]);
         b = sgn ? longint'($signed(mb[kk][c])) : longint'(mb[kk][c]);
         s += a * b;
      end
      return s;
   endfunction

   function automatic logic [31:0] fmt(input longint v, input int w, input bit sgn, input bit sat);
      longint      hi, lo;
      logic [63:0] t;
      if (sat) begin
         if (sgn) begin
            hi = (longint'(1) <<< (w - 1)) - 1;
            lo = -(longint'(1) <<< (w - 1));
         end else begin
            hi = (longint'(1) <<< w) - 1;
            lo = 0;
         end
         if (v > hi) v = hi;
         else if (v < lo) v = lo;
      end
      t = v;
      t = t & ((64'd1 << w) - 64'd1);
      return t[31:0];
   endfunction

   task automatic run_job(input int n, input bit sgn, input bit sat,
                          input int gap, input int stall, input bit poke);
      got.delete();
      @(negedge clk);
      start = 1'b1; mat_n = 4'(n); signed_mode = sgn; sat_en = sat;
      @(negedge clk);
      start = 1'b0;
      fork
         begin
            int t;
            for (int r = 0; r < n; r++)
               for (int c = 0; c < n; c++)
                  for (int kk = 0; kk < n; kk++) begin
                     if (poke && r == 0 && c == 0 && kk == 1) begin
                        bus.op_valid = 1'b0;
                        start = 1'b1; mat_n = 4'd2;
                        @(negedge clk);
                        start = 1'b0;
                     end
                     while ($urandom_range(99) < gap) begin
                        bus.op_valid = 1'b0;
                        @(negedge clk);
                     end
                     bus.op_valid = 1'b1;
                     bus.a_data = ma[r][kk];
                     bus.b_data = mb[kk][c];
                     t = 0;
                     while (!bus.op_ready) begin
                        @(negedge clk);
                        if (++t > 5000) bail("op_ready wait");
                     end
                     @(negedge clk);
                  end
            bus.op_valid = 1'b0;
         end
         begin
            int   t;
            res_t cur;
            logic [63:0] snap;
            for (int e = 0; e < n * n; e++) begin
               t = 0;
               while (!bus.res_valid) begin
                  @(negedge clk);
                  if (++t > 5000) bail("res_valid wait");
               end
               cur = '{bus.res_row, bus.res_col, bus.res_data, bus16.res_data, bus.res_last};
               snap = {bus.res_valid, bus.res_data, bus16.res_data, bus.res_row, bus.res_col, bus.res_last};
               for (int s = 0; s < stall; s++) begin
                  @(negedge clk);
                  chk("stall stability",
                      {bus.res_valid, bus.res_data, bus16.res_data, bus.res_row, bus.res_col, bus.res_last},
                      snap);
               end
               bus.res_ready = 1'b1;
               @(negedge clk);
               bus.res_ready = 1'b0;
               got.push_back(cur);
               if (e == n * n - 1) begin
                  chk("done pulse", done, 1);
                  @(negedge clk);
                  chk("done cleared", done, 0);
                  chk("busy after done", busy, 0);
               end
            end
         end
      join
   endtask

   task automatic check_results(input int n, input bit sgn, input bit sat);
      longint v;
      chk("result count", got.size(), n * n);
      for (int i = 0; i < got.size() && i < n * n; i++) begin
         v = elem(n, i / n, i % n, sgn);
         chk("res_row", got[i].row, i / n);
         chk("res_col", got[i].col, i % n);
         chk("res_data32", got[i].d32, fmt(v, 32, sgn, sat));
         chk("res_data16", got[i].d16, fmt(v, 16, sgn, sat));
         chk("res_last", got[i].last, (i == n * n - 1));
      end
   endtask

   initial begin
      int          e0;
      logic [31:0] exp45 [4];
      exp45 = '{32'd19, 32'd22, 32'd43, 32'd50};

      tbl[0] = '{0, 0, 16'd3,    16'd5,    32'd15,         16'd15};
      tbl[1] = '{1, 0, 16'hFFFD, 16'd7,    32'hFFFFFFEB,   16'hFFEB};
      tbl[2] = '{1, 1, 16'hFFFD, 16'd7,    32'hFFFFFFEB,   16'hFFEB};
      tbl[3] = '{0, 1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001,   16'hFFFF};
      tbl[4] = '{0, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001,   16'h0001};
      tbl[5] = '{1, 1, 16'h8000, 16'h8000, 32'h40000000,   16'h7FFF};
      tbl[6] = '{1, 1, 16'h8000, 16'h7FFF, 32'hC0008000,   16'h8000};
      tbl[7] = '{1, 0, 16'h8000, 16'h7FFF, 32'hC0008000,   16'h8000};
      tbl[8] = '{0, 0, 16'h0000, 16'd1234, 32'd0,          16'd0};

      rst = 1'b1; start = 1'b0; mat_n = '0; signed_mode = 1'b0; sat_en = 1'b0;
      bus.op_valid = 1'b0; bus.a_data = '0; bus.b_data = '0; bus.res_ready = 1'b0;
      #12;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      chk("reset op_ready", bus.op_ready, 0);
      chk("reset res_valid", bus.res_valid, 0);
      chk("reset res_data", bus.res_data, 0);
      chk("reset res_row", bus.res_row, 0);
      chk("reset res_col", bus.res_col, 0);
      chk("reset res_last", bus.res_last, 0);
      @(negedge clk);
      rst = 1'b0;

      // N=1 vectors: one pair in, one result out the following cycle
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         start = 1'b1; mat_n = 4'd1; signed_mode = tbl[i].sgn; sat_en = tbl[i].sat;
         @(negedge clk);
         start = 1'b0;
         chk("busy after start", busy, 1);
         bus.op_valid = 1'b1; bus.a_data = tbl[i].a; bus.b_data = tbl[i].b;
         chk("op_ready in ACC", bus.op_ready, 1);
         @(negedge clk);
         bus.op_valid = 1'b0;
         chk("res_valid latency", bus.res_valid, 1);
         chk("vec res_data32", bus.res_data, tbl[i].e32);
         chk("vec res_data16", bus16.res_data, tbl[i].e16);
         chk("vec res_last", bus.res_last, 1);
         chk("vec res_rowcol", {bus.res_row, bus.res_col}, 0);
         bus.res_ready = 1'b1;
         @(negedge clk);
         bus.res_ready = 1'b0;
         chk("vec done", done, 1);
         @(negedge clk);
         chk("vec done cleared", done, 0);
         chk("vec idle", busy, 0);
      end

      ma[0][0] = 16'd1; ma[0][1] = 16'd2; ma[1][0] = 16'd3; ma[1][1] = 16'd4;
      mb[0][0] = 16'd5; mb[0][1] = 16'd6; mb[1][0] = 16'd7; mb[1][1] = 16'd8;
      run_job(2, 0, 0, 0, 0, 0);
      chk("2x2 count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         chk("2x2 data", got[i].d32, exp45[i]);
         chk("2x2 last", got[i].last, (i == 3));
      end

      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            ma[r][c] = 16'h7FFF; mb[r][c] = 16'h7FFF;
         end
      run_job(2, 1, 1, 0, 0, 0);
      for (int i = 0; i < got.size(); i++) chk("sat16 max", got[i].d16, 16'h7FFF);
      check_results(2, 1, 1);
      run_job(2, 1, 0, 0, 0, 0);
      for (int i = 0; i < got.size(); i++) chk("trunc16", got[i].d16, 16'h0002);
      check_results(2, 1, 0);

      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            ma[r][c] = (r == c) ? 16'd1 : 16'd0;
            mb[r][c] = 16'($urandom);
         end
      e0 = err_seen;
      run_job(3, 0, 0, 40, 5, 1);
      chk("start ignored mid-job", err_seen - e0, 0);
      for (int i = 0; i < got.size(); i++)
         chk("identity C==B", got[i].d32, {16'd0, mb[i / 3][i % 3]});
      check_results(3, 0, 0);

      e0 = err_seen;
      @(negedge clk); start = 1'b1; mat_n = 4'd0;
      @(negedge clk); start = 1'b0;
      chk("err n=0", err, 1);
      chk("busy n=0", busy, 0);
      @(negedge clk);
      chk("err one cycle", err, 0);
      start = 1'b1; mat_n = 4'd9;
      @(negedge clk); start = 1'b0;
      chk("err n=9", err, 1);
      chk("busy n=9", busy, 0);
      @(negedge clk);
      chk("err count", err_seen - e0, 2);
      chk("busy after errs", busy, 0);

      @(negedge clk);
      start = 1'b1; mat_n = 4'd4; signed_mode = 1'b1; sat_en = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < 3; p++) begin
         bus.op_valid = 1'b1; bus.a_data = 16'd1234; bus.b_data = 16'd567;
         @(negedge clk);
      end
      bus.op_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("abort busy", busy, 0);
      chk("abort op_ready", bus.op_ready, 0);
      chk("abort res_valid", bus.res_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            ma[r][c] = 16'($urandom_range(100));
            mb[r][c] = 16'($urandom_range(100));
         end
      run_job(2, 0, 0, 20, 0, 0);
      check_results(2, 0, 0);

      for (int j = 0; j < 6; j++) begin
         int n;
         bit sgn, sat, wide;
         n = $urandom_range(1, 8);
         sgn = 1'($urandom_range(1));
         sat = 1'($urandom_range(1));
         wide = 1'($urandom_range(1));
         for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
               ma[r][c] = wide ? 16'($urandom) : 16'($urandom_range(300));
               mb[r][c] = wide ? 16'($urandom) : 16'($urandom_range(300));
            end
         run_job(n, sgn, sat, 30, j % 3, 0);
         check_results(n, sgn, sat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
